// File: rtl/hamming_decoder.sv
// Receive-side (7,4) Hamming stage: deserializes codewords, corrects single-bit errors,
// and re-serializes the data. Define HAMMING_DECODER_ERRCNT_EN to enable the corrected-word counter.
module hamming_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_in,
  input  logic       s_valid,
  input  logic       sync_clr,
  output logic [3:0] data_out,
  output logic       data_valid,
  output logic       err_corrected,
  output logic [2:0] syndrome,
  output logic       s_out,
  output logic       s_out_valid,
  output logic [7:0] err_count
);

  typedef enum logic {IDLE, SHIFT} ser_state_t;

  ser_state_t state;
  logic [2:0] bit_cnt;
  logic [5:0] sr;
  logic       complete;
  logic [6:0] cw;
  logic [6:0] cw_fix;
  logic [2:0] syn;
  logic [3:0] data_fix;
  logic [2:0] sh_data;
  logic [1:0] sh_cnt;

  // sync_clr suppresses completion even when it coincides with the 7th bit
  always_comb begin
    complete = s_valid && !sync_clr && (bit_cnt == 3'd6);
    cw       = {sr, s_in};
    syn      = {cw[3] ^ cw[4] ^ cw[5] ^ cw[6],
                cw[1] ^ cw[2] ^ cw[5] ^ cw[6],
                cw[0] ^ cw[2] ^ cw[4] ^ cw[6]};
    cw_fix   = cw;
    if (syn != 3'd0)
      cw_fix = cw ^ (7'd1 << (syn - 3'd1));
    data_fix = {cw_fix[6], cw_fix[5], cw_fix[4], cw_fix[2]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt <= 3'd0;
      sr      <= 6'd0;
    end else if (sync_clr) begin
      bit_cnt <= 3'd0;
      sr      <= 6'd0;
    end else if (s_valid) begin
      sr      <= {sr[4:0], s_in};
      bit_cnt <= complete ? 3'd0 : bit_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out      <= 4'd0;
      data_valid    <= 1'b0;
      err_corrected <= 1'b0;
      syndrome      <= 3'd0;
    end else begin
      data_valid <= complete;
      if (complete) begin
        data_out      <= data_fix;
        syndrome      <= syn;
        err_corrected <= (syn != 3'd0);
      end
    end
  end

  // A completion always (re)loads the serializer, even mid-burst
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      s_out       <= 1'b0;
      s_out_valid <= 1'b0;
      sh_data     <= 3'd0;
      sh_cnt      <= 2'd0;
    end else if (complete) begin
      state       <= SHIFT;
      s_out       <= data_fix[3];
      s_out_valid <= 1'b1;
      sh_data     <= data_fix[2:0];
      sh_cnt      <= 2'd0;
    end else begin
      case (state)
        SHIFT: begin
          if (sh_cnt == 2'd3) begin
            state       <= IDLE;
            s_out       <= 1'b0;
            s_out_valid <= 1'b0;
          end else begin
            s_out   <= sh_data[2];
            sh_data <= {sh_data[1:0], 1'b0};
            sh_cnt  <= sh_cnt + 2'd1;
          end
        end
        default: begin
          s_out       <= 1'b0;
          s_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAMMING_DECODER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_count <= 8'd0;
    else if (complete && (syn != 3'd0) && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed and random codewords checked against
// a position-XOR Hamming model; honours HAMMING_DECODER_ERRCNT_EN for err_count expectations.
module tb_hamming_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_in;
  logic       s_valid;
  logic       sync_clr;
  logic [3:0] data_out;
  logic       data_valid;
  logic       err_corrected;
  logic [2:0] syndrome;
  logic       s_out;
  logic       s_out_valid;
  logic [7:0] err_count;

  int vectors     = 0;
  int miscompares = 0;
  int model_errs  = 0;
  int dv_count    = 0;

  logic [7:0] dv_q[$];
  logic       ser_q[$];

  hamming_decoder dut (
    .clk           (clk),
    .reset         (reset),
    .s_in          (s_in),
    .s_valid       (s_valid),
    .sync_clr      (sync_clr),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .err_corrected (err_corrected),
    .syndrome      (syndrome),
    .s_out         (s_out),
    .s_out_valid   (s_out_valid),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  // Outputs are observed on the falling edge, well away from the active edge
  always @(negedge clk) begin
    if (data_valid) begin
      dv_count++;
      dv_q.push_back({err_corrected, syndrome, data_out});
    end
    if (s_out_valid)
      ser_q.push_back(s_out);
  end

  // Reference model: syndrome is the XOR of the 1-based positions of all set bits
  function automatic logic [2:0] model_syndrome(input logic [6:0] c);
    logic [2:0] s = 3'd0;
    for (int p = 1; p <= 7; p++)
      if (c[p-1]) s ^= 3'(p);
    return s;
  endfunction

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] c = 7'd0;
    logic [2:0] s;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    s    = model_syndrome(c);
    c[0] = s[0];
    c[1] = s[1];
    c[3] = s[2];
    return c;
  endfunction

  function automatic logic [7:0] expected_err_count();
`ifdef HAMMING_DECODER_ERRCNT_EN
    return 8'(model_errs);
`else
    return 8'd0;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic bit_v, input logic valid, input logic clr);
    s_in     = bit_v;
    s_valid  = valid;
    sync_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [6:0] c, input bit gap);
    for (int i = 6; i >= 0; i--) begin
      apply_stimulus(c[i], 1'b1, 1'b0);
      if (gap) apply_stimulus(1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'b0);
  endtask

  // Decode one word through the model and compare the captured pulse and serial burst
  task automatic check_word(input string tag, input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] fixed;
    logic [3:0] d;
    logic [7:0] rec;
    logic [3:0] ser;
    s     = model_syndrome(c);
    fixed = c;
    if (s != 3'd0) fixed[s-1] = ~fixed[s-1];
    d = {fixed[6], fixed[5], fixed[4], fixed[2]};
    if (s != 3'd0 && model_errs < 255) model_errs++;
    check_output({tag, "/pulses"}, dv_q.size(), 1);
    if (dv_q.size() > 0) begin
      rec = dv_q.pop_front();
      check_output({tag, "/data_out"}, rec[3:0], d);
      check_output({tag, "/syndrome"}, rec[6:4], s);
      check_output({tag, "/err_corrected"}, rec[7], (s != 3'd0));
    end
    check_output({tag, "/serial_len"}, ser_q.size(), 4);
    if (ser_q.size() == 4) begin
      ser = {ser_q[0], ser_q[1], ser_q[2], ser_q[3]};
      check_output({tag, "/serial_bits"}, ser, d);
    end
    check_output({tag, "/err_count"}, err_count, expected_err_count());
  endtask

  task automatic send_word(input string tag, input logic [6:0] c, input bit gap);
    dv_q.delete();
    ser_q.delete();
    send_bits(c, gap);
    idle(6);
    check_word(tag, c);
  endtask

  initial begin
    int         dv_before;
    logic [6:0] c;
    int         e;

    reset    = 1'b0;
    s_in     = 1'b0;
    s_valid  = 1'b0;
    sync_clr = 1'b0;
    @(posedge clk);
    #1;

    // Held in reset with a toggling input: nothing may move
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(1'(i), 1'b1, 1'b0);
      check_output("reset/outputs",
                   {data_out, data_valid, err_corrected, syndrome, s_out, s_out_valid, err_count},
                   21'd0);
    end
    check_output("reset/no_pulse", dv_count, 0);
    reset = 1'b1;
    idle(2);

    send_word("clean", 7'b1010101, 1'b0);
    send_word("single_err", 7'b1000101, 1'b0);
    check_output("single_err/model_syn", model_syndrome(7'b1000101), 3'd5);

    dv_before = dv_count;
    send_word("gapped", 7'b1111111, 1'b1);
    check_output("gapped/total_pulses", dv_count - dv_before, 1);

    // Three stray bits, then sync_clr together with a valid bit, then a clean zero word
    dv_q.delete();
    ser_q.delete();
    dv_before = dv_count;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    send_bits(7'b0000000, 1'b0);
    idle(6);
    check_word("framing", 7'b0000000);
    check_output("framing/total_pulses", dv_count - dv_before, 1);

    for (int n = 0; n < 30; n++) begin
      c = encode(4'($urandom_range(0, 15)));
      e = $urandom_range(0, 7);
      if (e != 0) c[e-1] = ~c[e-1];
      send_word("random", c, bit'($urandom_range(0, 1)));
    end

    // 256 back-to-back erroneous words drive the counter into saturation
    dv_before = dv_count;
    for (int n = 0; n < 256; n++) begin
      c = encode(4'($urandom_range(0, 15)));
      e = $urandom_range(1, 7);
      c[e-1] = ~c[e-1];
      if (model_errs < 255) model_errs++;
      send_bits(c, 1'b0);
    end
    idle(6);
    check_output("saturate/pulses", dv_count - dv_before, 256);
    check_output("saturate/err_count", err_count, expected_err_count());

    // Reset mid-serialization and mid-word
    dv_q.delete();
    ser_q.delete();
    send_bits(7'b1000101, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    model_errs = 0;
    check_output("midreset/err_count", err_count, 8'd0);
    check_output("midreset/s_out_valid", s_out_valid, 1'b0);
    check_output("midreset/data_out", {data_valid, data_out}, 5'd0);
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    idle(1);
    send_word("after_reset", encode(4'b0110), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
